// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with
// frame-synchronised value updates, per-digit blink and leading-zero blanking.
module ssd_scan_ctrl #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  blink_in,
    input  logic        lz_blank_en,
    output logic [3:0]  ssd_ctl,
    output logic [3:0]  bcd_out,
    output logic [1:0]  digit_idx,
    output logic        frame_tick,
    output logic        upd_pending
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [BW-1:0] blk_cnt_q, blk_cnt_d;
    logic          phase_q, phase_d;
    logic [15:0]   act_val_q, act_val_d;
    logic [3:0]    act_mask_q, act_mask_d;
    logic [15:0]   pend_val_q, pend_val_d;
    logic [3:0]    pend_mask_q, pend_mask_d;
    logic          upd_q, upd_d;

    logic term;
    logic boundary;

    assign term     = (cnt_q == CNT_LAST);
    assign boundary = enable && term && (dig_q == 2'd3);

    always_comb begin
        cnt_d       = cnt_q;
        dig_d       = dig_q;
        blk_cnt_d   = blk_cnt_q;
        phase_d     = phase_q;
        act_val_d   = act_val_q;
        act_mask_d  = act_mask_q;
        pend_val_d  = pend_val_q;
        pend_mask_d = pend_mask_q;
        upd_d       = upd_q;
        if (!enable) begin
            cnt_d = '0;
            dig_d = 2'd0;
            upd_d = 1'b0;
            if (load) begin
                act_val_d  = value_in;
                act_mask_d = blink_in;
            end else if (upd_q) begin
                act_val_d  = pend_val_q;
                act_mask_d = pend_mask_q;
            end
        end else begin
            if (term) begin
                cnt_d = '0;
                dig_d = dig_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            // A load on the boundary bypasses the pending stage entirely
            if (load && boundary) begin
                act_val_d  = value_in;
                act_mask_d = blink_in;
                upd_d      = 1'b0;
            end else if (load) begin
                pend_val_d  = value_in;
                pend_mask_d = blink_in;
                upd_d       = 1'b1;
            end else if (boundary && upd_q) begin
                act_val_d  = pend_val_q;
                act_mask_d = pend_mask_q;
                upd_d      = 1'b0;
            end
            if (boundary) begin
                if (blk_cnt_q == BLK_LAST) begin
                    blk_cnt_d = '0;
                    phase_d   = ~phase_q;
                end else begin
                    blk_cnt_d = blk_cnt_q + BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            dig_q       <= 2'd0;
            blk_cnt_q   <= '0;
            phase_q     <= 1'b0;
            act_val_q   <= 16'h0000;
            act_mask_q  <= 4'b0000;
            pend_val_q  <= 16'h0000;
            pend_mask_q <= 4'b0000;
            upd_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            dig_q       <= dig_d;
            blk_cnt_q   <= blk_cnt_d;
            phase_q     <= phase_d;
            act_val_q   <= act_val_d;
            act_mask_q  <= act_mask_d;
            pend_val_q  <= pend_val_d;
            pend_mask_q <= pend_mask_d;
            upd_q       <= upd_d;
        end
    end

    logic [15:0] upper;
    logic [3:0]  nib;

    assign upper = act_val_q >> {dig_q, 2'b00};
    assign nib   = upper[3:0];

    always_comb begin
        bcd_out = nib;
        if (!enable) begin
            bcd_out = 4'hF;
        end else if (phase_q && act_mask_q[dig_q]) begin
            bcd_out = 4'hF;
        end else if (lz_blank_en && (dig_q != 2'd0) && (upper == 16'h0000)) begin
            bcd_out = 4'hF;
        end
    end

    assign ssd_ctl     = enable ? ~(4'b0001 << dig_q) : 4'b1111;
    assign digit_idx   = dig_q;
    assign frame_tick  = boundary;
    assign upd_pending = upd_q;

endmodule
